// File: rtl/muntjac_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : muntjac_timer_if                                          |
// | Purpose  : Request/response register bus between a bus master and    |
// |            the muntjac_timer machine-timer block.                    |
// | Ports    : req_* carry the request (valid/ready handshake),          |
// |            rsp_* carry the response (valid/ready handshake).         |
// |            Signal suffixes are named from the timer's point of view. |
// | Modports : slave  - timer side                                       |
// |            master - requester side                                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface muntjac_timer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [15:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wmask_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_error_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wmask_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );
endinterface
`default_nettype wire

// File: rtl/muntjac_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : muntjac_timer                                             |
// | Purpose  : RISC-V machine timer (msip / mtimecmp / mtime) behind a   |
// |            one-outstanding-request register bus.                     |
// | Ports    : clk_i            - sole clock, rising edge                |
// |            rst_ni           - asynchronous active-low reset          |
// |            bus              - register bus (muntjac_timer_if.slave)  |
// |            irq_software_m_o - msip bit 0                             |
// |            irq_timer_m_o    - registered (mtime >= mtimecmp)         |
// | Map      : 0x0000 msip, 0x4000 mtimecmp, 0xBFF8 mtime                |
// | Options  : MUNTJAC_TIMER_WRITE_MTIME_EN - makes mtime writable;      |
// |            when undefined mtime writes are accepted and ignored.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module muntjac_timer #(
  parameter int unsigned TickDivide    = 1,
  parameter logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  muntjac_timer_if.slave    bus,
  output logic              irq_software_m_o,
  output logic              irq_timer_m_o
);

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_MTIMECMP = 16'h4000;
  localparam logic [15:0] ADDR_MTIME    = 16'hBFF8;
  localparam logic [15:0] TICK_LAST     = 16'(TickDivide - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] prescale_q, prescale_d;
  logic        msip_q, msip_d;
  logic        irq_timer_q, irq_timer_d;

  logic        hit_msip, hit_cmp, hit_mtime, hit_any;
  logic        accept, wr_en;
  logic [63:0] rd_value;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wmask);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (wmask[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  // Full 16-bit compare: any address with addr[2:0] != 0 misses every
  // register and therefore reports an error.
  assign hit_msip  = (bus.req_addr_i == ADDR_MSIP);
  assign hit_cmp   = (bus.req_addr_i == ADDR_MTIMECMP);
  assign hit_mtime = (bus.req_addr_i == ADDR_MTIME);
  assign hit_any   = hit_msip | hit_cmp | hit_mtime;

  assign accept = (state_q == IDLE) && bus.req_valid_i;
  // A zero byte mask is a no-op write and must not steal a tick.
  assign wr_en  = accept && bus.req_write_i && hit_any && (|bus.req_wmask_i);

  always_comb begin
    rd_value = 64'd0;
    if (hit_msip)  rd_value = {63'd0, msip_q};
    if (hit_cmp)   rd_value = mtimecmp_q;
    if (hit_mtime) rd_value = mtime_q;
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    prescale_d  = prescale_q;
    msip_d      = msip_q;
    irq_timer_d = (mtime_q >= mtimecmp_q);

    if (prescale_q == TICK_LAST) begin
      prescale_d = 16'd0;
      mtime_d    = mtime_q + 64'd1;
    end else begin
      prescale_d = prescale_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = RESP;
          rsp_error_d = ~hit_any;
          rsp_rdata_d = (bus.req_write_i || !hit_any) ? 64'd0 : rd_value;
        end
        if (wr_en) begin
          if (hit_msip && bus.req_wmask_i[0]) msip_d = bus.req_wdata_i[0];
          if (hit_cmp) begin
            mtimecmp_d = merge_bytes(mtimecmp_q, bus.req_wdata_i, bus.req_wmask_i);
          end
`ifdef MUNTJAC_TIMER_WRITE_MTIME_EN
          // The written value wins over a coincident tick.
          if (hit_mtime) begin
            mtime_d = merge_bytes(mtime_q, bus.req_wdata_i, bus.req_wmask_i);
          end
`else
          // mtime is read-only: the access completes, nothing is stored.
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rsp_rdata_q <= 64'd0;
      rsp_error_q <= 1'b0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= MtimecmpReset;
      prescale_q  <= 16'd0;
      msip_q      <= 1'b0;
      irq_timer_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      prescale_q  <= prescale_d;
      msip_q      <= msip_d;
      irq_timer_q <= irq_timer_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_error_o = rsp_error_q;

  assign irq_software_m_o = msip_q;
  assign irq_timer_m_o    = irq_timer_q;

endmodule
`default_nettype wire
